// File: rtl/div_sched_pkg.sv
// Shared definitions for the RV32M divide sequencer: M-extension funct3
// codes, the R-type M opcode and the sequencer state encoding.
package div_sched_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;

  // R-type opcode shared by all M-extension instructions
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

  // funct3 codes of the divide/remainder group
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sched_core.sv
// Unsigned radix-2 restoring divider datapath.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : load operands, clear remainder, counter = XLEN
//   step             : perform one restoring iteration
//   dividend_i/divisor_i : unsigned operand magnitudes
//   done_c           : combinational, high on the final iteration
//   quotient_o/remainder_o : current quotient / partial remainder
module div_core
  import div_sched_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_c,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    trial;

  // quo_q starts as the dividend and shifts quotient bits in from the right,
  // so its MSB is always the next dividend bit to bring down.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(XLEN);
    end else if (step) begin
      // no borrow: the subtraction fits, keep it and set the quotient bit
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_c      = step && (cnt_q == CNT_W'(1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/div_sched.sv
// Execute-stage sequencer for DIV/DIVU/REM/REMU on an iterative divider.
// Ports:
//   clk, rst_n        : clock, synchronous reset (active-high despite name)
//   req_valid_i, funct3_i, dividend_i, divisor_i, rd_i : request from ex
//   flush_i           : kills the in-flight op
//   req_ready_o       : high in IDLE
//   busy_o            : op in flight (CALC or DONE)
//   hold_flag_o       : combinational pipeline hold (accept cycle and CALC)
//   result_valid_o, rd_wr_en_o, rd_o, result_o : one-cycle writeback
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            result_valid_o,
  output logic            rd_wr_en_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            is_rem_q, is_rem_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;

  logic            accept, signed_op, is_rem, div_zero, ovf, special;
  logic            core_start, core_step, core_done;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, quo, rem, core_res, res;

  // Request decode, operand magnitudes and special-case bypass
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_valid_i && !flush_i;
    signed_op = (funct3_i == INST_DIV) || (funct3_i == INST_REM);
    is_rem    = (funct3_i == INST_REM) || (funct3_i == INST_REMU);
    a_mag     = (signed_op && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    b_mag     = (signed_op && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    div_zero  = (divisor_i == '0);
    ovf       = signed_op && (dividend_i == INT_MIN) && (divisor_i == '1);
    special   = div_zero || ovf;
    // x/0: q = all ones, r = x;  INT_MIN/-1: q = INT_MIN (the dividend), r = 0
    if (div_zero) spec_res = is_rem ? dividend_i : '1;
    else          spec_res = is_rem ? '0 : dividend_i;
    core_start = accept && !special;
    core_step  = (state_q == ST_CALC);
  end

  // Next state and operation latches
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    is_rem_d   = is_rem_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_d       = rd_i;
          is_rem_d   = is_rem;
          special_d  = special;
          spec_res_d = spec_res;
          q_neg_d    = (funct3_i == INST_DIV) && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          r_neg_d    = (funct3_i == INST_REM) && dividend_i[XLEN-1];
          state_d    = special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush_i)        state_d = ST_IDLE;
        else if (core_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      is_rem_q   <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      is_rem_q   <= is_rem_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
    end
  end

  div_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst_n),
    .start       (core_start),
    .step        (core_step),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .done_c      (core_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Final sign fix-up of the unsigned core result
  always_comb begin
    if (is_rem_q) core_res = r_neg_q ? -rem : rem;
    else          core_res = q_neg_q ? -quo : quo;
    res = special_q ? spec_res_q : core_res;
  end

  // A flush arriving in DONE must swallow the pulse in that same cycle
  assign result_valid_o = (state_q == ST_DONE) && !flush_i;
  assign rd_wr_en_o     = result_valid_o && (rd_q != 5'd0);
  assign rd_o           = result_valid_o ? rd_q : 5'd0;
  assign result_o       = result_valid_o ? res : '0;
  assign req_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign hold_flag_o    = (state_q == ST_CALC) || accept;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed ops with literal expectations
// plus a cycle-level reference model compared on every clock.
module tb_div_sched;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, hold_flag_o, result_valid_o, rd_wr_en_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;

  div_sched #(.XLEN(32), .CNT_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .funct3_i       (funct3_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .hold_flag_o    (hold_flag_o),
    .result_valid_o (result_valid_o),
    .rd_wr_en_o     (rd_wr_en_o),
    .rd_o           (rd_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // model state: the accepted op lives in (acc_cyc, min(done_cyc, kill_cyc)]
  int          acc_cyc  = -1;
  int          done_cyc = -1;
  int          kill_cyc = 1 << 30;
  logic [31:0] exp_res  = '0;
  logic [4:0]  exp_rd   = '0;
  bit          chk_en   = 1'b0;

  int          last_pulse_cyc = -1;
  logic [31:0] last_res = '0;
  logic        last_wen = 1'b0;
  logic [4:0]  last_rd  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic sgn;
    logic is_r;
    sgn  = (f3 == F_DIV) || (f3 == F_REM);
    is_r = (f3 == F_REM) || (f3 == F_REMU);
    if (b == 32'd0) return is_r ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_r ? 32'd0 : 32'h8000_0000;
    case (f3)
      F_DIV:   return 32'($signed(a) / $signed(b));
      F_REM:   return 32'($signed(a) % $signed(b));
      F_DIVU:  return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int end_cycle();
    return (done_cyc < kill_cyc) ? done_cyc : kill_cyc;
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit in_op, calc, v, hold_e;
      in_op  = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc <= end_cycle());
      calc   = in_op && (cyc < done_cyc);
      v      = in_op && (cyc == done_cyc) && !flush_i;
      hold_e = calc || (!in_op && req_valid_i && !flush_i);
      chk("req_ready_o", 32'(req_ready_o), 32'(!in_op));
      chk("busy_o", 32'(busy_o), 32'(in_op));
      chk("hold_flag_o", 32'(hold_flag_o), 32'(hold_e));
      chk("result_valid_o", 32'(result_valid_o), 32'(v));
      chk("rd_wr_en_o", 32'(rd_wr_en_o), 32'(v && exp_rd != 5'd0));
      chk("rd_o", 32'(rd_o), v ? 32'(exp_rd) : 32'd0);
      chk("result_o", result_o, v ? exp_res : 32'd0);
      if (result_valid_o === 1'b1) begin
        last_pulse_cyc = cyc;
        last_res       = result_o;
        last_wen       = rd_wr_en_o;
        last_rd        = rd_o;
      end
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle and record what the model expects
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bit special;
    special = (b == 32'd0) ||
              (((f3 == F_DIV) || (f3 == F_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    funct3_i       = f3;
    dividend_i     = a;
    divisor_i      = b;
    rd_i           = rd;
    req_valid_i    = 1'b1;
    acc_cyc        = cyc;
    done_cyc       = cyc + (special ? 1 : 33);
    kill_cyc       = 1 << 30;
    exp_res        = model_res(f3, a, b);
    exp_rd         = rd;
    last_pulse_cyc = -1;
    step_cyc();
    req_valid_i    = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_lit,
                        input int lat_lit, input bit poke);
    issue(f3, a, b, rd);
    if (poke) begin
      // a request during CALC must be ignored
      repeat (3) step_cyc();
      funct3_i    = F_DIVU;
      dividend_i  = 32'd1;
      divisor_i   = 32'd1;
      rd_i        = 5'd1;
      req_valid_i = 1'b1;
      step_cyc();
      req_valid_i = 1'b0;
    end
    while (cyc <= end_cycle()) step_cyc();
    chk({nm, " result"}, last_res, exp_lit);
    chk({nm, " latency"}, 32'(last_pulse_cyc - acc_cyc), 32'(lat_lit));
    chk({nm, " rd_wr_en"}, 32'(last_wen), 32'(rd != 5'd0));
    chk({nm, " rd"}, 32'(last_rd), 32'(rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset req_ready_o", 32'(req_ready_o), 32'd1);
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset result_valid_o", 32'(result_valid_o), 32'd0);
    chk("reset result_o", result_o, 32'd0);
    step_cyc();

    run_op("DIVU 100/7",   F_DIVU, 32'd100,         32'd7,          5'd5, 32'd14,         33, 1'b1);
    run_op("REM -7/2",     F_REM,  32'hFFFF_FFF9,   32'd2,          5'd6, 32'hFFFF_FFFF,  33, 1'b0);
    run_op("DIV -7/2",     F_DIV,  32'hFFFF_FFF9,   32'd2,          5'd7, 32'hFFFF_FFFD,  33, 1'b0);
    run_op("REMU big/2",   F_REMU, 32'hFFFF_FFF9,   32'd2,          5'd8, 32'd1,          33, 1'b0);
    run_op("DIV 7/-2",     F_DIV,  32'd7,           32'hFFFF_FFFE,  5'd9, 32'hFFFF_FFFD,  33, 1'b0);
    run_op("REM 7/-2",     F_REM,  32'd7,           32'hFFFF_FFFE,  5'd10, 32'd1,         33, 1'b0);
    run_op("DIVU max/1",   F_DIVU, 32'hFFFF_FFFF,   32'd1,          5'd11, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("DIVU 5/0",     F_DIVU, 32'd5,           32'd0,          5'd12, 32'hFFFF_FFFF, 1,  1'b0);
    run_op("REM 5/0",      F_REM,  32'd5,           32'd0,          5'd13, 32'd5,         1,  1'b0);
    run_op("DIV ovf",      F_DIV,  32'h8000_0000,   32'hFFFF_FFFF,  5'd14, 32'h8000_0000, 1,  1'b0);
    run_op("REM ovf",      F_REM,  32'h8000_0000,   32'hFFFF_FFFF,  5'd15, 32'd0,         1,  1'b0);

    // flush at T+10 of a long op
    issue(F_DIVU, 32'd100, 32'd3, 5'd3);
    while (cyc < acc_cyc + 10) step_cyc();
    flush_i  = 1'b1;
    kill_cyc = cyc;
    step_cyc();
    flush_i  = 1'b0;
    @(negedge clk);
    chk("flush busy_o", 32'(busy_o), 32'd0);
    chk("flush req_ready_o", 32'(req_ready_o), 32'd1);
    chk("flush no pulse", 32'(last_pulse_cyc), 32'hFFFF_FFFF);
    step_cyc();
    run_op("DIVU 9/3", F_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33, 1'b0);

    // flush together with a request in IDLE: not accepted
    funct3_i    = F_DIVU;
    dividend_i  = 32'd6;
    divisor_i   = 32'd2;
    req_valid_i = 1'b1;
    flush_i     = 1'b1;
    step_cyc();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk);
    chk("flush+req busy_o", 32'(busy_o), 32'd0);
    step_cyc();

    // flush in DONE swallows the pulse
    issue(F_DIVU, 32'd5, 32'd0, 5'd2);
    flush_i  = 1'b1;
    kill_cyc = cyc;
    step_cyc();
    flush_i  = 1'b0;
    chk("flush in DONE no pulse", 32'(last_pulse_cyc), 32'hFFFF_FFFF);

    // reset at T+20 of an op
    issue(F_DIVU, 32'd1000, 32'd7, 5'd9);
    while (cyc < acc_cyc + 20) step_cyc();
    rst_n    = 1'b1;
    kill_cyc = cyc;
    step_cyc();
    rst_n    = 1'b0;
    @(negedge clk);
    chk("rst req_ready_o", 32'(req_ready_o), 32'd1);
    chk("rst busy_o", 32'(busy_o), 32'd0);
    chk("rst hold_flag_o", 32'(hold_flag_o), 32'd0);
    chk("rst result_valid_o", 32'(result_valid_o), 32'd0);
    chk("rst rd_o", 32'(rd_o), 32'd0);
    chk("rst result_o", result_o, 32'd0);
    step_cyc();

    run_op("DIVU 8/2 rd0", F_DIVU, 32'd8, 32'd2, 5'd0, 32'd4, 33, 1'b0);

    step_cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
